// File: rtl/mem_request_unit_pkg.sv
// Shared definitions for the memory request unit: bus widths, memoryModule
// command encodings, FSM state encodings and a small command helper.
package mem_request_unit_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // memoryModule cntrl encodings; 2'b11 is never driven.
    typedef enum logic [1:0] {
        CNTRL_NOP   = 2'b00,
        CNTRL_READ  = 2'b01,
        CNTRL_WRITE = 2'b10
    } cntrl_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RESP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CLEAR = 3'd4
    } state_e;

    function automatic cntrl_e access_cntrl(input logic is_write);
        return is_write ? CNTRL_WRITE : CNTRL_READ;
    endfunction

endpackage

// File: rtl/mem_request_unit_if.sv
// CPU-side request/response channel of the memory request unit.
//   master: the CPU datapath (drives requests, accepts responses)
//   slave : mem_request_unit (accepts requests, returns responses)
// Request:  reqValid/reqReady handshake carrying reqWrite, reqIndirect,
//           reqAddr, reqWdata.
// Response: respValid/respReady handshake carrying respRdata, respErr.
interface mem_request_unit_if;
    import mem_request_unit_pkg::*;

    logic              reqValid;
    logic              reqReady;
    logic              reqWrite;
    logic              reqIndirect;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqWdata;
    logic              respValid;
    logic              respReady;
    logic [DATA_W-1:0] respRdata;
    logic              respErr;

    modport master (
        output reqValid, reqWrite, reqIndirect, reqAddr, reqWdata, respReady,
        input  reqReady, respValid, respRdata, respErr
    );

    modport slave (
        input  reqValid, reqWrite, reqIndirect, reqAddr, reqWdata, respReady,
        output reqReady, respValid, respRdata, respErr
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Saturating cycle counter that flags when an access phase has lasted
// TIMEOUT cycles. Shared by the REQ and DRAIN phases.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : force count to zero (wins over en)
//   en       : count one cycle
//   hit      : count equals TIMEOUT-1 (this is the last allowed cycle)
module mem_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);
    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] HIT_VAL = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturate at all-ones so a stalled enable can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == HIT_VAL);

endmodule

// File: rtl/mem_request_unit.sv
// Upstream sequencer for memoryModule. Accepts one CPU load/store at a time,
// holds start/cntrl/isIndirect/addr/dataIn steady until dataReady (or a
// timeout), returns the result on the response channel, then waits for
// dataReady to fall before accepting the next request. RAM clears are
// sequenced as a fixed-length clrRAM pulse, deferred until the unit is idle.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   cpu           : CPU request/response channel (slave side)
//   clrReq        : one-cycle RAM clear request
//   busy          : unit is not idle
//   start, cntrl, isIndirect, addr, dataIn, clrRAM : to memoryModule
//   dataOut, dataReady                             : from memoryModule
module mem_request_unit
    import mem_request_unit_pkg::*;
#(
    parameter int TIMEOUT    = 64,
    parameter int CLR_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_request_unit_if.slave cpu,
    input  logic              clrReq,
    output logic              busy,
    output logic              start,
    output logic [1:0]        cntrl,
    output logic              isIndirect,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dataIn,
    output logic              clrRAM,
    input  logic [DATA_W-1:0] dataOut,
    input  logic              dataReady
);
    localparam int CLR_W = $clog2(CLR_CYCLES + 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    state_e            state_q, state_d;
    logic              clr_pend_q, clr_pend_d;
    logic              write_q, write_d;
    logic              ind_q, ind_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;

    logic req_ready;
    logic resp_valid;
    logic tmo_clr;
    logic tmo_en;
    logic tmo_hit;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (tmo_clr),
        .en  (tmo_en),
        .hit (tmo_hit)
    );

    always_comb begin
        state_d    = state_q;
        clr_pend_d = clr_pend_q;
        write_d    = write_q;
        ind_d      = ind_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        clr_cnt_d  = clr_cnt_q;

        req_ready  = 1'b0;
        resp_valid = 1'b0;
        start      = 1'b0;
        cntrl      = CNTRL_NOP;
        isIndirect = 1'b0;
        addr       = '0;
        dataIn     = '0;
        clrRAM     = 1'b0;
        // The timeout counter only runs in REQ and DRAIN; it sits at zero
        // everywhere else, so each of those phases starts from a fresh count.
        tmo_clr    = 1'b1;
        tmo_en     = 1'b0;

        // Clears requested while busy are remembered; repeats merge into one.
        if (clrReq && (state_q != ST_IDLE)) begin
            clr_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // A clear in the same cycle wins, so the CPU must not see a
                // completed handshake for a request that is not captured.
                req_ready = !clr_pend_q && !clrReq;
                if (clrReq || clr_pend_q) begin
                    clr_pend_d = 1'b0;
                    clr_cnt_d  = '0;
                    state_d    = ST_CLEAR;
                end else if (cpu.reqValid) begin
                    write_d = cpu.reqWrite;
                    ind_d   = cpu.reqIndirect;
                    addr_d  = cpu.reqAddr;
                    wdata_d = cpu.reqWdata;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                start      = 1'b1;
                cntrl      = access_cntrl(write_q);
                isIndirect = ind_q;
                addr       = addr_q;
                dataIn     = wdata_q;
                tmo_clr    = 1'b0;
                tmo_en     = 1'b1;
                if (dataReady) begin
                    rdata_d = write_q ? '0 : dataOut;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (cpu.respReady) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Keep start low until memoryModule drops dataReady, otherwise
                // the next access could see a stale ready on its first cycle.
                tmo_clr = 1'b0;
                tmo_en  = 1'b1;
                if (!dataReady || tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clrRAM = 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            clr_pend_q <= 1'b0;
            write_q    <= 1'b0;
            ind_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            clr_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_pend_q <= clr_pend_d;
            write_q    <= write_d;
            ind_q      <= ind_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign cpu.reqReady  = req_ready;
    assign cpu.respValid = resp_valid;
    assign cpu.respRdata = rdata_q;
    assign cpu.respErr   = err_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// Bench for mem_request_unit: a behavioural memoryModule (configurable
// latency, never-ready mode, dataReady hold after start falls) plus a
// reference memory image that predicts what each CPU load must return.
module tb_mem_request_unit;
    localparam int TIMEOUT    = 64;
    localparam int CLR_CYCLES = 4;
    localparam int LIMIT      = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clrReq = 1'b0;
    logic       busy, start, isIndirect, clrRAM;
    logic [1:0] cntrl;
    logic [7:0] addr, dataIn;
    logic [7:0] dataOut = 8'h00;
    logic       dataReady = 1'b0;

    mem_request_unit_if cpu_if ();

    mem_request_unit #(.TIMEOUT(TIMEOUT), .CLR_CYCLES(CLR_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu        (cpu_if),
        .clrReq     (clrReq),
        .busy       (busy),
        .start      (start),
        .cntrl      (cntrl),
        .isIndirect (isIndirect),
        .addr       (addr),
        .dataIn     (dataIn),
        .clrRAM     (clrRAM),
        .dataOut    (dataOut),
        .dataReady  (dataReady)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] env_mem [256];
    logic [7:0] ref_mem [256];
    int mem_lat   = 1;
    bit mem_never = 1'b0;
    int mem_hold  = 0;
    int scnt      = 0;
    int hold_rem  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; afterwards the memory model reacts to the DUT outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (clrRAM) begin
            for (int i = 0; i < 256; i++) env_mem[i] = 8'h00;
        end
        if (start) begin
            scnt++;
            if (!mem_never && scnt >= mem_lat) begin
                if (!dataReady) begin
                    if (cntrl == 2'b10) env_mem[addr] = dataIn;
                    hold_rem = mem_hold;
                end
                dataReady = 1'b1;
                dataOut   = (cntrl == 2'b01) ? env_mem[addr] : 8'hEE;
            end else begin
                dataReady = 1'b0;
            end
        end else begin
            scnt = 0;
            if (hold_rem > 0) begin
                dataReady = 1'b1;
                hold_rem--;
            end else begin
                dataReady = 1'b0;
            end
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic do_access(input string name, input bit wr, input bit ind,
                             input logic [7:0] a, input logic [7:0] wd,
                             input int lat, input bit never, input int hold,
                             input int rdelay, input bit clr_before, input bit clr_during);
        int starts;
        int drain;
        int ncl;
        int exp_drain;
        bit ok;
        logic [7:0] exp_rdata;
        mem_lat = lat; mem_never = never; mem_hold = hold;
        for (int w = 0; w < LIMIT && !cpu_if.reqReady; w++) tick();
        check({name, "/ready"}, cpu_if.reqReady, 1);
        cpu_if.reqValid = 1'b1; cpu_if.reqWrite = wr; cpu_if.reqIndirect = ind;
        cpu_if.reqAddr = a; cpu_if.reqWdata = wd;
        clrReq = clr_before;
        tick();
        clrReq = 1'b0;
        if (clr_before) begin
            ncl = 0;
            while (clrRAM && ncl < LIMIT) begin ncl++; tick(); end
            check({name, "/clr_len"}, ncl, CLR_CYCLES);
            clear_ref();
            check({name, "/ready_after_clr"}, cpu_if.reqReady, 1);
            tick();
        end
        cpu_if.reqValid = 1'b0;
        clrReq = clr_during;
        starts = 0; ok = 1'b1;
        while (start && starts < LIMIT) begin
            ok = ok && (cntrl == (wr ? 2'b10 : 2'b01)) && (isIndirect == ind) &&
                 (addr == a) && (dataIn == wd) && !cpu_if.respValid && !cpu_if.reqReady;
            starts++;
            tick();
            clrReq = 1'b0;
        end
        clrReq = 1'b0;
        check({name, "/req_stable"}, ok, 1);
        check({name, "/req_cycles"}, starts, never ? TIMEOUT : lat);
        exp_rdata = (wr || never) ? 8'h00 : ref_mem[a];
        if (wr && !never) ref_mem[a] = wd;
        check({name, "/resp_valid"}, cpu_if.respValid, 1);
        check({name, "/resp_rdata"}, cpu_if.respRdata, exp_rdata);
        check({name, "/resp_err"}, cpu_if.respErr, never);
        check({name, "/resp_cntrl"}, {start, cntrl}, 0);
        ok = 1'b1;
        for (int k = 0; k < rdelay; k++) begin
            tick();
            ok = ok && cpu_if.respValid && (cpu_if.respRdata == exp_rdata) &&
                 (cpu_if.respErr == never) && !cpu_if.reqReady && !start;
        end
        check({name, "/resp_hold"}, ok, 1);
        cpu_if.respReady = 1'b1;
        tick();
        cpu_if.respReady = 1'b0;
        check({name, "/resp_drop"}, cpu_if.respValid, 0);
        drain = 0;
        while (busy && !start && !cpu_if.respValid && !clrRAM && drain < LIMIT) begin
            drain++;
            tick();
        end
        exp_drain = never ? 1 : ((hold > rdelay + 1) ? hold - (rdelay + 1) : 0) + 1;
        if (exp_drain > TIMEOUT) exp_drain = TIMEOUT;
        check({name, "/drain_cycles"}, drain, exp_drain);
        check({name, "/idle_dready"}, {busy, dataReady}, 0);
        if (clr_during) begin
            check({name, "/pend_blocks"}, cpu_if.reqReady, 0);
            tick();
            ncl = 0;
            while (clrRAM && ncl < LIMIT) begin ncl++; tick(); end
            check({name, "/clr_len"}, ncl, CLR_CYCLES);
            clear_ref();
        end
        $display("access %s wr=%0d ind=%0d addr=%02h wdata=%02h rdata=%02h err=%0d",
                 name, wr, ind, a, wd, exp_rdata, never);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cpu_if.reqValid = 1'b0; cpu_if.reqWrite = 1'b0; cpu_if.reqIndirect = 1'b0;
        cpu_if.reqAddr = 8'h00; cpu_if.reqWdata = 8'h00; cpu_if.respReady = 1'b0;
        for (int i = 0; i < 256; i++) begin env_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        env_mem[8'h3C] = 8'hA5; ref_mem[8'h3C] = 8'hA5;

        // Reset state
        #12;
        check("rst/ctrl_outs", {busy, start, cntrl, clrRAM, isIndirect}, 0);
        check("rst/bus_outs", {addr, dataIn}, 0);
        check("rst/resp", {cpu_if.respValid, cpu_if.respErr, cpu_if.respRdata}, 0);
        check("rst/req_ready", cpu_if.reqReady, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst/ready", {cpu_if.reqReady, busy}, 2'b10);

        // Directed accesses
        do_access("load_3c", 1'b0, 1'b0, 8'h3C, 8'h00, 3, 1'b0, 0, 0, 1'b0, 1'b0);
        do_access("store_10", 1'b1, 1'b1, 8'h10, 8'h5A, 2, 1'b0, 0, 0, 1'b0, 1'b0);
        do_access("load_10", 1'b0, 1'b0, 8'h10, 8'h00, 1, 1'b0, 0, 0, 1'b0, 1'b0);
        do_access("timeout", 1'b0, 1'b0, 8'h3C, 8'h00, 1, 1'b1, 0, 0, 1'b0, 1'b0);
        do_access("clr_same", 1'b0, 1'b0, 8'h3C, 8'h00, 1, 1'b0, 0, 0, 1'b1, 1'b0);
        do_access("store_22", 1'b1, 1'b0, 8'h22, 8'hC3, 2, 1'b0, 0, 0, 1'b0, 1'b0);
        do_access("clr_in_req", 1'b0, 1'b1, 8'h22, 8'h00, 3, 1'b0, 0, 0, 1'b0, 1'b1);
        do_access("load_22_clr", 1'b0, 1'b0, 8'h22, 8'h00, 1, 1'b0, 0, 0, 1'b0, 1'b0);
        do_access("resp_stall", 1'b1, 1'b0, 8'h30, 8'h77, 2, 1'b0, 0, 10, 1'b0, 1'b0);
        do_access("drain_hold", 1'b0, 1'b0, 8'h30, 8'h00, 1, 1'b0, 5, 0, 1'b0, 1'b0);
        do_access("after_hold", 1'b0, 1'b1, 8'h30, 8'h00, 1, 1'b0, 0, 0, 1'b0, 1'b0);

        // Randomized accesses against the reference image
        for (int n = 0; n < 24; n++) begin
            do_access("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'(8'h40 + $urandom_range(0, 7)), 8'($urandom),
                      int'($urandom_range(1, 4)), 1'b0, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        // Reset in the middle of REQ
        mem_never = 1'b1;
        cpu_if.reqValid = 1'b1; cpu_if.reqWrite = 1'b0; cpu_if.reqAddr = 8'h41;
        tick();
        cpu_if.reqValid = 1'b0;
        repeat (5) tick();
        check("midrst/pre_start", {start, cntrl}, 3'b101);
        #2;
        rst = 1'b1;
        #1;
        check("midrst/drop", {start, cntrl, busy, cpu_if.respValid}, 0);
        check("midrst/ready", cpu_if.reqReady, 1);
        dataReady = 1'b0; scnt = 0; hold_rem = 0; mem_never = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        check("midrst/no_resp", {cpu_if.respValid, busy, start}, 0);
        check("midrst/ready_after", cpu_if.reqReady, 1);
        $display("access midrst addr=41 discarded");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
